// File: rtl/and_checker_pkg.sv
// Shared types and helpers for the AND-gate truth-table checker.
// Optional behaviour is selected with AND_CHECKER_STOP_ON_FAIL_EN (see top).
package and_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_N_IN          = 2;
  localparam int DEF_SETTLE_CYCLES = 2;

  function automatic int nvec_f(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int err_w_f(input int nvec);
    return $clog2(nvec + 1);
  endfunction

  // Reduction AND over the low n_in bits of the applied vector.
  function automatic logic exp_and(input logic [31:0] vec, input int n_in);
    logic r;
    r = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i < n_in) begin
        r = r & vec[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/and_truth_table_checker_settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
module settle_timer #(
  parameter int CW       = 1,
  parameter int LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [CW-1:0] cnt_r;

  // Counter register: load wins over decrement, holds at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= CW'(LOAD_VAL);
    end else if (en && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/and_truth_table_checker.sv
// Walks every input vector through the gate, samples c after a settle interval
// and records mismatches. Define AND_CHECKER_STOP_ON_FAIL_EN to end on first mismatch.
module and_truth_table_checker
  import and_checker_pkg::*;
#(
  parameter int N_IN          = DEF_N_IN,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  localparam int NVEC         = nvec_f(N_IN),
  localparam int ERR_W        = err_w_f(NVEC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  stim,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [NVEC-1:0]  fail_vec
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [N_IN-1:0]  VEC_ONE  = N_IN'(1);
  localparam logic [N_IN-1:0]  VEC_LAST = N_IN'(NVEC - 1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  state_t           state_r;
  logic [N_IN-1:0]  vec_r;
  logic [N_IN-1:0]  stim_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [ERR_W-1:0] err_count_r;
  logic [NVEC-1:0]  fail_vec_r;

  logic             exp_s;
  logic             mismatch_s;
  logic             stop_s;
  logic             start_run_s;
  logic             finish_s;
  logic             advance_s;
  logic             tmr_zero_s;
  logic [ERR_W-1:0] err_next_s;

`ifdef AND_CHECKER_STOP_ON_FAIL_EN
  assign stop_s = mismatch_s;
`else
  assign stop_s = 1'b0;
`endif

  // Decode of run start, vector advance and run completion.
  always_comb begin
    exp_s       = exp_and(32'(stim_r), N_IN);
    mismatch_s  = (c != exp_s);
    start_run_s = 1'b0;
    finish_s    = 1'b0;
    advance_s   = 1'b0;
    if (((state_r == IDLE) || (state_r == DONE)) && start) begin
      start_run_s = 1'b1;
    end else if (state_r == SAMPLE) begin
      finish_s  = (vec_r == VEC_LAST) || stop_s;
      advance_s = !finish_s;
    end else begin
      start_run_s = 1'b0;
    end
    if (mismatch_s) begin
      err_next_s = err_count_r + ERR_ONE;
    end else begin
      err_next_s = err_count_r;
    end
  end

  settle_timer #(
    .CW      (CW),
    .LOAD_VAL(SETTLE_CYCLES - 1)
  ) u_settle_timer (
    .clk (clk),
    .rst (rst),
    .load(start_run_s || advance_s),
    .en  (state_r == SETTLE),
    .zero(tmr_zero_s)
  );

  // Run-control FSM with vector counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      vec_r       <= {N_IN{1'b0}};
      stim_r      <= {N_IN{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_count_r <= {ERR_W{1'b0}};
      fail_vec_r  <= {NVEC{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start_run_s) begin
            state_r     <= SETTLE;
            vec_r       <= {N_IN{1'b0}};
            stim_r      <= {N_IN{1'b0}};
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_count_r <= {ERR_W{1'b0}};
            fail_vec_r  <= {NVEC{1'b0}};
          end
        end
        SETTLE: begin
          if (tmr_zero_s) begin
            state_r <= SAMPLE;
          end
        end
        SAMPLE: begin
          err_count_r <= err_next_s;
          if (mismatch_s) begin
            fail_vec_r[vec_r] <= 1'b1;
          end
          if (finish_s) begin
            state_r <= DONE;
            stim_r  <= {N_IN{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_next_s == {ERR_W{1'b0}});
          end else begin
            state_r <= SETTLE;
            vec_r   <= vec_r + VEC_ONE;
            stim_r  <= vec_r + VEC_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign stim      = stim_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_count_r;
  assign fail_vec  = fail_vec_r;

endmodule

// File: tb/tb_and_truth_table_checker.sv
// Directed bench for the truth-table checker: a 2-input instance with a
// selectable gate model and a 3-input instance with SETTLE_CYCLES=1.
module tb_and_truth_table_checker;

  typedef struct {
    int          done_edge;
    int          err;
    logic [31:0] fv;
    logic        pass;
  } res_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sel;
  int          mode;

  logic [1:0]  stim_a;
  logic        c_a;
  logic        busy_a, done_a, pass_a;
  logic [2:0]  err_a;
  logic [3:0]  fv_a;

  logic [2:0]  stim_b;
  logic        c_b;
  logic        busy_b, done_b, pass_b;
  logic [3:0]  err_b;
  logic [7:0]  fv_b;

  logic [31:0] o_stim, o_err, o_fv;
  logic        o_busy, o_done, o_pass;

  int          errors = 0;
  int          checks = 0;
  int          stim_q[$];
  res_t        res_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate models: 0 = AND, 1 = OR, 2 = stuck-at-1
  always_comb begin
    case (mode)
      0:       c_a = stim_a[0] & stim_a[1];
      1:       c_a = stim_a[0] | stim_a[1];
      default: c_a = 1'b1;
    endcase
    c_b = stim_b[0] & stim_b[1] & stim_b[2];
  end

  and_truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start && !sel), .stim(stim_a), .c(c_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .fail_vec(fv_a)
  );

  and_truth_table_checker #(.N_IN(3), .SETTLE_CYCLES(1)) dut3 (
    .clk(clk), .rst(rst), .start(start && sel), .stim(stim_b), .c(c_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .fail_vec(fv_b)
  );

  always_comb begin
    o_stim = sel ? 32'(stim_b) : 32'(stim_a);
    o_err  = sel ? 32'(err_b)  : 32'(err_a);
    o_fv   = sel ? 32'(fv_b)   : 32'(fv_a);
    o_busy = sel ? busy_b : busy_a;
    o_done = sel ? done_b : done_a;
    o_pass = sel ? pass_b : pass_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic gate_out(input int m, input int v, input int nin);
    case (m)
      0:       return (v == (1 << nin) - 1);
      1:       return (v != 0);
      default: return 1'b1;
    endcase
  endfunction

  // Push the expected stim-per-edge trace and the final result for one run.
  task automatic predict(input int m, input int nin, input int settle);
    res_t r;
    int   per;
    per         = settle + 1;
    r.err       = 0;
    r.fv        = 32'h0;
    r.done_edge = (1 << nin) * per;
    for (int v = 0; v < (1 << nin); v++) begin
      if (gate_out(m, v, nin) != (v == (1 << nin) - 1)) begin
        r.err++;
        r.fv[v] = 1'b1;
`ifdef AND_CHECKER_STOP_ON_FAIL_EN
        r.done_edge = (v + 1) * per;
        break;
`endif
      end
    end
    r.pass = (r.err == 0);
    for (int k = 0; k < r.done_edge; k++) begin
      stim_q.push_back(k / per);
    end
    res_q.push_back(r);
  endtask

  // One full run; optionally pulses start at edges 4 and 7 while busy.
  task automatic run(input int m, input int nin, input int settle, input bit pulse_busy);
    res_t r;
    int   e;
    int   exp_stim;
    mode = m;
    predict(m, nin, settle);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_cleared_at_start", 32'(o_done), 32'h0);
    e = 0;
    while (!o_done && e < 64) begin
      if (stim_q.size() == 0) begin
        chk("stim_q_underflow", 32'(e), 32'hFFFF_FFFF);
        exp_stim = -1;
      end else begin
        exp_stim = stim_q.pop_front();
      end
      chk("stim", o_stim, 32'(exp_stim));
      chk("busy", 32'(o_busy), 32'h1);
      start = pulse_busy && (e == 3 || e == 6);
      tick();
      e++;
    end
    start = 1'b0;
    r = res_q.pop_front();
    chk("done_edge", 32'(e), 32'(r.done_edge));
    chk("stim_q_empty", 32'(stim_q.size()), 32'h0);
    chk("err_count", o_err, 32'(r.err));
    chk("fail_vec", o_fv, r.fv);
    chk("pass", 32'(o_pass), 32'(r.pass));
    chk("busy_done", 32'(o_busy), 32'h0);
    chk("stim_done", o_stim, 32'h0);
    stim_q.delete();
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_stim"}, o_stim, 32'h0);
    chk({tag, "_busy"}, 32'(o_busy), 32'h0);
    chk({tag, "_done"}, 32'(o_done), 32'h0);
    chk({tag, "_pass"}, 32'(o_pass), 32'h0);
    chk({tag, "_err"}, o_err, 32'h0);
    chk({tag, "_fv"}, o_fv, 32'h0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    mode  = 0;
    tick();
    tick();
    chk_cleared("reset");

    // rst and start together: rst wins
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_cleared("rst_vs_start");
    rst = 1'b0;
    tick();
    chk("idle_after_rst", 32'(o_busy), 32'h0);

    run(0, 2, 2, 1'b0);
    tick();
    tick();
    chk("done_holds", 32'(o_done), 32'h1);
    chk("pass_holds", 32'(o_pass), 32'h1);

    // restart from DONE with OR and stuck-at-1 gates
    run(1, 2, 2, 1'b0);
    run(2, 2, 2, 1'b0);

    // reset asserted at edge 5 of a run
    mode  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cleared("midrun_rst");
    tick();
    chk("midrun_idle", 32'(o_busy), 32'h0);
    run(0, 2, 2, 1'b0);

    // start pulses while busy are ignored
    run(0, 2, 2, 1'b1);

    // 3-input instance, one settle cycle
    sel = 1'b1;
    run(0, 3, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/and_truth_table_checker.md
Name: and_truth_table_checker

Overview:
- Self-checking stimulus/response stage wrapped around the 2-input AND gate.
- Drives every input combination on `stim`, waits a settle interval, samples the gate output `c`, and compares it against the expected AND of `stim`.
- Records per-vector failures and an error count, then reports `done`/`pass`.
- Sits directly upstream (drives `a`, `b`) and downstream (consumes `c`) of the gate. Used as an on-chip/bench-level truth-table checker.

Parameters:
- N_IN, 2, number of gate inputs; vectors 0..2**N_IN-1 are applied.
- SETTLE_CYCLES, 2, cycles `stim` is held before `c` is sampled; must be >=1.
- Derived localparams: NVEC = 2**N_IN; ERR_W = $clog2(NVEC+1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a check run; sampled only in IDLE or DONE.
- stim  output  N_IN  stimulus to the gate; stim[0] drives `a`, stim[1] drives `b`.
- c  input  1  gate output under test.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next start or reset.
- pass  output  1  high only when done=1 and err_count=0.
- err_count  output  ERR_W  number of mismatching vectors in the last run.
- fail_vec  output  NVEC  bit i set if vector i mismatched.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, vector index=0, settle counter=0.
- Reset mid-run aborts immediately with no partial results retained.
- Expected value: exp = &stim (reduction AND of the currently applied vector).
- States and transitions:
  - IDLE: busy=0. On start=1 → SETTLE with vec=0, stim=0, cnt=SETTLE_CYCLES-1, err_count=0, fail_vec=0, done=0, busy=1.
  - SETTLE: stim held. If cnt==0 → SAMPLE, else cnt--.
  - SAMPLE, one cycle:
    - Compare c to exp.
    - On mismatch: err_count++, fail_vec[vec]=1.
    - If vec==NVEC-1 → DONE; else vec++, stim=vec+1, cnt reload, → SETTLE.
  - DONE: busy=0, done=1, stim returns to 0, pass=(err_count==0).
    - start=1 restarts exactly as from IDLE; done drops the same edge.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - With start sampled at edge 0, done rises at edge NVEC*(SETTLE_CYCLES+1). Defaults: edge 12.
- start while busy=1 is ignored.
- Simultaneous rst and start: rst wins.
- Sampling rule: `c` is sampled only in SAMPLE; glitches during SETTLE are not observed.
- err_count cannot overflow, since its maximum is NVEC and ERR_W covers it.
- The vector index wraps only via restart, never mid-run.

Optional Feature:
- Macro: AND_CHECKER_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE goes directly to DONE.
  - err_count=1 and exactly one fail_vec bit is set.
  - Remaining vectors are not applied.
- Undefined: all NVEC vectors are always applied, and every mismatch is recorded.

Decomposition:
- Package and_checker_pkg:
  - State enum {IDLE, SETTLE, SAMPLE, DONE}.
  - Localparam helpers for NVEC/ERR_W.
  - Function exp_and(vector) returning the expected response.
- One sub-module: settle_timer.
  - Loadable down-counter with a load input, load value SETTLE_CYCLES-1, and a zero flag.
  - Instantiated once.
- FSM, vector counter, and result registers stay in the top.

Test Plan:
1. Correct gate, defaults: reset, pulse start → stim sequence 00,01,10,11 each held 3 cycles; done at edge 12; err_count=0, fail_vec=4'b0000, pass=1.
2. Faulty gate modelled as OR: run → mismatches at vectors 1,2; err_count=2, fail_vec=4'b0110, pass=0.
3. Stuck-at-1 `c`: run → err_count=3, fail_vec=4'b0111. With AND_CHECKER_STOP_ON_FAIL_EN: done at edge 3, err_count=1, fail_vec=4'b0001.
4. Reset mid-run: assert rst at edge 5 → next cycle all outputs zero, state IDLE. A fresh start then gives a clean pass.
5. Start pulsed during busy at edges 4 and 7 → ignored; done still at edge 12. Start in DONE → restart with done cleared the same edge.
6. SETTLE_CYCLES=1, N_IN=3 with a 3-input AND model → 8 vectors at 2 cycles each, done at edge 16, pass=1.
